// File: rtl/clkgen_pkg.sv
// Shared constants and types for the multi-channel clock-enable generator.
// Channel roles and default divisors carried over from the fixed /3 /4 /5 generator.
package clkgen_pkg;

   localparam int CNT_W_DEF = 4;

   localparam int CH_CPU    = 0;
   localparam int CH_DSP    = 1;
   localparam int CH_CHROMA = 2;
   localparam int CH_PIX    = 3;

   // Divisors are period-1: /5, /3, /4 and /5.
   localparam int unsigned DIV_CPU_SLOW    = 4;
   localparam int unsigned DIV_CPU_FAST    = 2;
   localparam int unsigned DIV_CHROMA_PAL  = 3;
   localparam int unsigned DIV_CHROMA_NTSC = 4;

   typedef struct packed {
      logic rise;
      logic fall;
      logic lvl;
   } ch_out_t;

endpackage

// File: rtl/clkgen_channel.sv
// One divider channel: period counter, shadowed divisor/high time,
// and the rise/fall/level decode gated by reset, enable and test mode.
module clkgen_channel
   import clkgen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             resync_i,
   input  logic             tst_i,
   input  logic             tst_clk_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic [CNT_W-1:0] high_i,
   output ch_out_t          out_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] sdiv_q, sdiv_d;
   logic [CNT_W-1:0] shigh_q, shigh_d;
   logic             wrap;
   logic             reload;
   logic             dec_rise;
   logic             dec_fall;
   logic             dec_lvl;

   // Shadows only change when the counter restarts, so no runt periods.
   always_comb begin
      wrap    = (cnt_q == sdiv_q);
      reload  = tst_i | ~en_i | resync_i | wrap;
      cnt_d   = cnt_q + CNT_W'(1);
      sdiv_d  = sdiv_q;
      shigh_d = shigh_q;
      if (reload) begin
         cnt_d   = '0;
         sdiv_d  = div_i;
         shigh_d = high_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         sdiv_q  <= div_i;
         shigh_q <= high_i;
      end else begin
         cnt_q   <= cnt_d;
         sdiv_q  <= sdiv_d;
         shigh_q <= shigh_d;
      end
   end

   always_comb begin
      dec_lvl  = (cnt_q < shigh_q);
      dec_rise = (cnt_q == '0) && (shigh_q != '0);
      dec_fall = (cnt_q == shigh_q) && (shigh_q != '0)
              && (shigh_q <= sdiv_q);
   end

   always_comb begin
      out_o = '0;
      if (rst_i) begin
         out_o = '0;
      end else if (tst_i) begin
         out_o = {1'b1, 1'b0, tst_clk_i};
      end else if (en_i) begin
         out_o = {dec_rise, dec_fall, dec_lvl};
      end
   end

endmodule

// File: rtl/clkgen_multi_enable.sv
// Multi-channel clock-enable generator: NUM_CH independent dividers
// sharing reset, resync and test-mode control on MasterClock.
module clkgen_multi_enable
   import clkgen_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    MasterClock,
   input  logic                    Reset,
   input  logic [NUM_CH-1:0]       ChEn,
   input  logic [NUM_CH*CNT_W-1:0] Div,
   input  logic [NUM_CH*CNT_W-1:0] High,
   input  logic                    Resync,
   input  logic                    TstMode,
   input  logic                    TstClk,
   output logic [NUM_CH-1:0]       Rise,
   output logic [NUM_CH-1:0]       Fall,
   output logic [NUM_CH-1:0]       Lvl
);

   ch_out_t ch_o [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkgen_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk_i     (MasterClock),
         .rst_i     (Reset),
         .en_i      (ChEn[g]),
         .resync_i  (Resync),
         .tst_i     (TstMode),
         .tst_clk_i (TstClk),
         .div_i     (Div[g*CNT_W +: CNT_W]),
         .high_i    (High[g*CNT_W +: CNT_W]),
         .out_o     (ch_o[g])
      );

      assign Rise[g] = ch_o[g].rise;
      assign Fall[g] = ch_o[g].fall;
      assign Lvl[g]  = ch_o[g].lvl;
   end

endmodule
